// File: rtl/dma_xfer_ctrl_if.sv
// Host/address-counter port bundle of the DMA transfer sequencer.
// The host side is the master; the sequencer side is the slave.
interface dma_xfer_ctrl_if #(
  parameter int AW = 8,
  parameter int WW = 8
);
  localparam int DW = (AW > WW) ? AW : WW;

  logic          instr_valid;
  logic [2:0]    instr;
  logic [DW-1:0] din;
  logic          step;
  logic          addr_load;
  logic [AW-1:0] addr_data;
  logic          addr_enable;
  logic          addr_up;
  logic [WW-1:0] wc_out;
  logic [2:0]    ctrl_out;
  logic          busy;
  logic          done;

  modport master (
    output instr_valid, instr, din, step,
    input  addr_load, addr_data, addr_enable, addr_up, wc_out, ctrl_out, busy, done
  );

  modport slave (
    input  instr_valid, instr, din, step,
    output addr_load, addr_data, addr_enable, addr_up, wc_out, ctrl_out, busy, done
  );
endinterface

// File: rtl/dma_xfer_ctrl.sv
// Instruction-driven sequencer for the DMA address generator: decodes opcodes,
// holds control/shadow registers and the word counter, and drives the address counter.
module dma_xfer_ctrl #(
  parameter int AW = 8,
  parameter int WW = 8
) (
  input  logic           clk,
  input  logic           res,
  dma_xfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [2:0] {
    OP_WRCR   = 3'd0,
    OP_LDADDR = 3'd1,
    OP_LDWC   = 3'd2,
    OP_REINIT = 3'd3,
    OP_START  = 3'd4,
    OP_STOP   = 3'd5
  } op_e;

  state_e        state, state_n;
  logic [2:0]    ctrl, ctrl_n;
  logic [AW-1:0] addr_shadow, addr_shadow_n;
  logic [WW-1:0] wc_shadow, wc_shadow_n;
  logic [WW-1:0] wc, wc_n;
  logic [AW-1:0] addr_data, addr_data_n;
  logic          load, load_n;
  logic          enable, enable_n;
  logic          done, done_n;

  op_e  op;
  logic is_op;

  assign op    = op_e'(bus.instr);
  assign is_op = bus.instr_valid;

  always_ff @(posedge clk) begin
    if (res) begin
      state       <= IDLE;
      ctrl        <= 3'b001;
      addr_shadow <= '0;
      wc_shadow   <= '0;
      wc          <= '0;
      addr_data   <= '0;
      load        <= 1'b0;
      enable      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ctrl        <= ctrl_n;
      addr_shadow <= addr_shadow_n;
      wc_shadow   <= wc_shadow_n;
      wc          <= wc_n;
      addr_data   <= addr_data_n;
      load        <= load_n;
      enable      <= enable_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n       = state;
    ctrl_n        = ctrl;
    addr_shadow_n = addr_shadow;
    wc_shadow_n   = wc_shadow;
    wc_n          = wc;
    addr_data_n   = addr_data;
    load_n        = 1'b0;
    enable_n      = 1'b0;
    done_n        = done;

    if (state == RUN) begin
      // In RUN done is only a reload pulse, so it falls back low by default.
      done_n = 1'b0;
      if (is_op && op == OP_REINIT) begin
        wc_n        = wc_shadow;
        load_n      = 1'b1;
        addr_data_n = addr_shadow;
        state_n     = IDLE;
      end else begin
        if (bus.step && wc != '0) begin
          wc_n = wc - WW'(1);
          if (wc == WW'(1)) begin
            done_n = 1'b1;
            if (ctrl[1]) begin
              // The reload overwrites the counter, so it replaces the enable pulse.
              wc_n        = wc_shadow;
              load_n      = 1'b1;
              addr_data_n = addr_shadow;
            end else begin
              enable_n = 1'b1;
              state_n  = DONE;
            end
          end else begin
            enable_n = 1'b1;
            if (is_op && op == OP_STOP) state_n = IDLE;
          end
        end else if (is_op && op == OP_STOP) begin
          state_n = IDLE;
        end
      end
    end else if (is_op) begin
      case (op)
        OP_WRCR:   ctrl_n = bus.din[2:0];
        OP_LDADDR: begin
          addr_shadow_n = bus.din[AW-1:0];
          addr_data_n   = bus.din[AW-1:0];
          load_n        = 1'b1;
        end
        OP_LDWC: begin
          wc_shadow_n = bus.din[WW-1:0];
          wc_n        = bus.din[WW-1:0];
          done_n      = 1'b0;
        end
        OP_REINIT: begin
          wc_n        = wc_shadow;
          load_n      = 1'b1;
          addr_data_n = addr_shadow;
          done_n      = 1'b0;
          state_n     = IDLE;
        end
        OP_START: begin
          if (wc == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = RUN;
            done_n  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr_load   = load;
  assign bus.addr_data   = addr_data;
  assign bus.addr_enable = enable;
  assign bus.addr_up     = ctrl[0];
  assign bus.wc_out      = wc;
  assign bus.ctrl_out    = ctrl;
  assign bus.busy        = (state == RUN);
  assign bus.done        = done;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl: expected load/enable/done events go into a
// scoreboard queue that a negedge monitor drains as the DUT emits them.
module tb_dma_xfer_ctrl;

  localparam int AW = 8;
  localparam int WW = 8;

  localparam logic [2:0] WRCR = 3'd0, LDADDR = 3'd1, LDWC = 3'd2, REINIT = 3'd3,
                         START = 3'd4, STOP = 3'd5;
  localparam int EV_LOAD = 0, EV_EN = 1, EV_DONE = 2;

  typedef struct {
    int kind;
    int val;
  } evt_t;

  logic clk;
  logic res;
  int   n_cmp = 0;
  int   n_bad = 0;
  evt_t q[$];
  logic done_prev;

  dma_xfer_ctrl_if #(.AW(AW), .WW(WW)) bus ();

  dma_xfer_ctrl #(.AW(AW), .WW(WW)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic expect_evt(input int kind, input int val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic pop_chk(input int kind, input int act, input string name);
    evt_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: unexpected event, value %0d (0x%0h), scoreboard empty", name, act, act);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != act) begin
        n_bad++;
        $display("FAIL %s: got kind %0d value 0x%0h, expected kind %0d value 0x%0h",
                 name, kind, act, e.kind, e.val);
      end
    end
  endtask

  // Monitor: outputs are registered, so sampling on the falling edge is race-free.
  always @(negedge clk) begin
    if (bus.addr_load)   pop_chk(EV_LOAD, int'(bus.addr_data), "addr_load");
    if (bus.addr_enable) pop_chk(EV_EN,   int'(bus.wc_out),    "addr_enable");
    if (bus.done && !done_prev) pop_chk(EV_DONE, int'(bus.wc_out), "done_rise");
    if (bus.addr_load && bus.addr_enable) begin
      n_cmp++;
      n_bad++;
      $display("FAIL load_en_overlap: got load=1 enable=1, expected never both");
    end
    done_prev = bus.done;
  end

  // One clock of stimulus: drive at a falling edge, return at the next falling edge.
  task automatic tick(input logic v, input logic [2:0] op, input int d, input logic st);
    bus.instr_valid = v;
    bus.instr       = op;
    bus.din         = d[7:0];
    bus.step        = st;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 3'd6;
    bus.din         = '0;
    bus.step        = 1'b0;
  endtask

  initial begin
    done_prev       = 1'b0;
    res             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 3'd6;
    bus.din         = '0;
    bus.step        = 1'b0;
    @(negedge clk);
    tick(0, 3'd6, 0, 0);
    tick(0, 3'd6, 0, 0);
    res = 1'b0;

    // Reset state, then ten quiet cycles
    chk("rst_wc", int'(bus.wc_out), 0);
    chk("rst_ctrl", int'(bus.ctrl_out), 1);
    chk("rst_up", int'(bus.addr_up), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_data", int'(bus.addr_data), 0);
    repeat (10) tick(0, 3'd6, 0, 0);

    // Basic transfer of three words
    expect_evt(EV_LOAD, 8'h40);
    tick(1, LDADDR, 8'h40, 0);
    tick(1, LDWC, 3, 0);
    chk("t2_wc3", int'(bus.wc_out), 3);
    tick(1, START, 0, 0);
    chk("t2_busy", int'(bus.busy), 1);
    expect_evt(EV_EN, 2);
    expect_evt(EV_EN, 1);
    expect_evt(EV_EN, 0);
    expect_evt(EV_DONE, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 3'd6, 0, 1);
      if (i == 2) begin
        chk("t2_done", int'(bus.done), 1);
        chk("t2_busy_off", int'(bus.busy), 0);
      end
    end
    chk("t2_wc_hold", int'(bus.wc_out), 0);

    // Auto-reload, counting down
    tick(1, WRCR, 3'b010, 0);
    chk("t3_up", int'(bus.addr_up), 0);
    chk("t3_ctrl", int'(bus.ctrl_out), 2);
    expect_evt(EV_LOAD, 8'h10);
    tick(1, LDADDR, 8'h10, 0);
    tick(1, LDWC, 2, 0);
    tick(1, START, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_evt(EV_EN, 1);
      expect_evt(EV_LOAD, 8'h10);
      expect_evt(EV_DONE, 2);
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 3'd6, 0, 1);
      if (i % 2 == 1) begin
        chk("t3_busy", int'(bus.busy), 1);
        chk("t3_wc_reload", int'(bus.wc_out), 2);
        chk("t3_done_pulse", int'(bus.done), 1);
      end
    end
    tick(1, STOP, 0, 0);
    chk("t3_stop_busy", int'(bus.busy), 0);
    chk("t3_done_low", int'(bus.done), 0);
    tick(1, WRCR, 3'b001, 0);

    // STOP together with a step, then resume
    tick(1, LDWC, 4, 0);
    tick(1, START, 0, 0);
    expect_evt(EV_EN, 3);
    expect_evt(EV_EN, 2);
    expect_evt(EV_EN, 1);
    tick(0, 3'd6, 0, 1);
    tick(0, 3'd6, 0, 1);
    tick(1, STOP, 0, 1);
    chk("t4_wc1", int'(bus.wc_out), 1);
    chk("t4_busy_off", int'(bus.busy), 0);
    tick(1, START, 0, 0);
    chk("t4_busy_on", int'(bus.busy), 1);
    expect_evt(EV_EN, 0);
    expect_evt(EV_DONE, 0);
    tick(0, 3'd6, 0, 1);
    chk("t4_wc0", int'(bus.wc_out), 0);
    chk("t4_done", int'(bus.done), 1);
    chk("t4_busy_end", int'(bus.busy), 0);

    // START with a zero word count
    tick(1, LDWC, 0, 0);
    chk("t5_done_clr", int'(bus.done), 0);
    expect_evt(EV_DONE, 0);
    tick(1, START, 0, 0);
    chk("t5_done", int'(bus.done), 1);
    chk("t5_busy", int'(bus.busy), 0);
    tick(0, 3'd6, 0, 1);
    chk("t5_wc", int'(bus.wc_out), 0);

    // Ignored loads in RUN, REINIT with a step, reset mid-RUN
    expect_evt(EV_LOAD, 8'h20);
    tick(1, LDADDR, 8'h20, 0);
    tick(1, LDWC, 5, 0);
    tick(1, START, 0, 0);
    expect_evt(EV_EN, 4);
    tick(0, 3'd6, 0, 1);
    tick(1, LDADDR, 8'h99, 0);
    chk("t6_wc_ldaddr", int'(bus.wc_out), 4);
    tick(1, LDWC, 9, 0);
    chk("t6_wc_ldwc", int'(bus.wc_out), 4);
    chk("t6_busy", int'(bus.busy), 1);
    expect_evt(EV_LOAD, 8'h20);
    tick(1, REINIT, 0, 1);
    chk("t6_reinit_wc", int'(bus.wc_out), 5);
    chk("t6_reinit_busy", int'(bus.busy), 0);
    chk("t6_reinit_data", int'(bus.addr_data), 8'h20);
    tick(1, START, 0, 0);
    expect_evt(EV_EN, 4);
    tick(0, 3'd6, 0, 1);
    res = 1'b1;
    tick(0, 3'd6, 0, 1);
    res = 1'b0;
    chk("t6_rst_wc", int'(bus.wc_out), 0);
    chk("t6_rst_ctrl", int'(bus.ctrl_out), 1);
    chk("t6_rst_busy", int'(bus.busy), 0);
    chk("t6_rst_done", int'(bus.done), 0);
    chk("t6_rst_data", int'(bus.addr_data), 0);
    chk("t6_rst_en", int'(bus.addr_enable), 0);
    chk("t6_rst_load", int'(bus.addr_load), 0);
    repeat (4) tick(0, 3'd6, 0, 1);
    chk("t6_idle_wc", int'(bus.wc_out), 0);

    chk("scoreboard_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
